// File: rtl/rs_multi_pkg.sv
// rs_multi_pkg: shared types for the unified reservation station.
//   RS_DEPTH_DEF   default entry count
//   TAG_W          physical register tag width
//   FU_CLASS       functional-unit classes (ALU, MULT, MEM)
//   SRC_TAG        source operand tag with valid/ready bits
//   DECODER_PACKET decoded instruction carried through the RS
//   RS_ENTRY       one reservation-station slot
//   RS_IDX         entry index at the default depth
package rs_multi_pkg;

    localparam int RS_DEPTH_DEF = 8;
    localparam int TAG_W        = 6;
    // fu field is sized for up to 16 classes so the entry layout does not
    // depend on the NUM_FU parameter of the top.
    localparam int FU_FIELD_W   = 4;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_MEM  = 2'd2
    } FU_CLASS;

    typedef struct packed {
        logic [TAG_W-1:0] phys_reg;
        logic             valid;
        logic             ready;
    } SRC_TAG;

    typedef struct packed {
        logic [31:0]      inst;
        logic [TAG_W-1:0] dest;
        SRC_TAG           t1;
        SRC_TAG           t2;
    } DECODER_PACKET;

    typedef struct packed {
        logic                  busy;
        logic                  issued;
        logic [FU_FIELD_W-1:0] fu;
        DECODER_PACKET         pkt;
    } RS_ENTRY;

    typedef logic [$clog2(RS_DEPTH_DEF)-1:0] RS_IDX;

endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: picks the oldest entry out of an eligible vector.
//   older     in  DEPTH x DEPTH  older[i][j]=1 when entry i is older than j
//   eligible  in  DEPTH          candidate entries
//   found     out 1              any candidate present
//   oldest    out DEPTH          one-hot of the oldest candidate
//   idx       out IDX_W          index of the oldest candidate
module rs_age_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    input  logic [DEPTH-1:0]            eligible,
    output logic                        found,
    output logic [DEPTH-1:0]            oldest,
    output logic [IDX_W-1:0]            idx
);

    logic [DEPTH-1:0] blocked;

    // A candidate is the oldest when no other candidate is older than it.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            blocked[i] = 1'b0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                blocked[i] = blocked[i] | (eligible[j] & older[j][i]);
            end
        end
        oldest = eligible & ~blocked;
        found  = |eligible;
        idx    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (oldest[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/rs_multi.sv
// rs_multi: unified reservation station with multi-port CDB wakeup and
// oldest-ready select, one issue slot per functional-unit class.
//   clock, reset       system clock, synchronous active-high reset
//   flush              squash every entry at the next edge
//   dispatch_*         incoming instruction, target class, free-entry flag
//   cdb_en/cdb_tag     CDB_N broadcast ports for wakeup
//   fu_ready           per-class issue acceptance
//   issue_*            per-class issue valid, packet and entry index
//   release_en/idx     execute frees an issued entry
//   free_count         registered count of non-busy entries
// Build option: define RS_WAKEUP_ISSUE_EN to let a CDB match make an entry
// eligible in the same cycle (adds a cdb->issue combinational path).
module rs_multi
    import rs_multi_pkg::*;
#(
    parameter int RS_DEPTH = RS_DEPTH_DEF,
    parameter int NUM_FU   = 3,
    parameter int CDB_N    = 2,
    parameter int IDX_W    = $clog2(RS_DEPTH),
    parameter int FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             dispatch_en,
    input  DECODER_PACKET                    dispatch_packet,
    input  logic [FU_W-1:0]                  dispatch_fu,
    output logic                             dispatch_ready,
    input  logic [CDB_N-1:0]                 cdb_en,
    input  logic [CDB_N-1:0][TAG_W-1:0]      cdb_tag,
    input  logic [NUM_FU-1:0]                fu_ready,
    output logic [NUM_FU-1:0]                issue_en,
    output DECODER_PACKET [NUM_FU-1:0]       issue_packet,
    output logic [NUM_FU-1:0][IDX_W-1:0]     issue_idx,
    input  logic                             release_en,
    input  logic [IDX_W-1:0]                 release_idx,
    output logic [IDX_W:0]                   free_count
);

    RS_ENTRY                          ent      [RS_DEPTH];
    DECODER_PACKET                    view_pkt [RS_DEPTH];
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older, older_n;
    logic [RS_DEPTH-1:0]              wake1, wake2, issued_mask;
    logic [NUM_FU-1:0][RS_DEPTH-1:0]  elig, oldest_oh;
    logic [NUM_FU-1:0]                sel_found;
    logic [NUM_FU-1:0][IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]                 alloc_idx;
    logic                             do_dispatch, do_release;
    DECODER_PACKET                    cap_pkt;

    function automatic logic cdb_match(SRC_TAG s, logic [CDB_N-1:0] en,
                                       logic [CDB_N-1:0][TAG_W-1:0] tags);
        logic m;
        m = 1'b0;
        for (int unsigned k = 0; k < CDB_N; k++) begin
            if (en[k] && tags[k] == s.phys_reg) m = 1'b1;
        end
        return m & s.valid;
    endfunction

    // Wakeup matches and per-class eligibility.
    always_comb begin
        for (int unsigned i = 0; i < RS_DEPTH; i++) begin
            wake1[i]    = cdb_match(ent[i].pkt.t1, cdb_en, cdb_tag);
            wake2[i]    = cdb_match(ent[i].pkt.t2, cdb_en, cdb_tag);
            view_pkt[i] = ent[i].pkt;
`ifdef RS_WAKEUP_ISSUE_EN
            view_pkt[i].t1.ready = ent[i].pkt.t1.ready | wake1[i];
            view_pkt[i].t2.ready = ent[i].pkt.t2.ready | wake2[i];
`endif
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                elig[f][i] = ent[i].busy && !ent[i].issued
                          && ent[i].fu == FU_FIELD_W'(f)
                          && (!view_pkt[i].t1.valid || view_pkt[i].t1.ready)
                          && (!view_pkt[i].t2.valid || view_pkt[i].t2.ready);
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
        rs_age_select #(
            .DEPTH (RS_DEPTH),
            .IDX_W (IDX_W)
        ) u_sel (
            .older    (older),
            .eligible (elig[f]),
            .found    (sel_found[f]),
            .oldest   (oldest_oh[f]),
            .idx      (sel_idx[f])
        );
    end

    always_comb begin
        issued_mask = '0;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            issue_en[f]     = sel_found[f] & fu_ready[f];
            issue_idx[f]    = sel_idx[f];
            issue_packet[f] = view_pkt[sel_idx[f]];
            if (issue_en[f]) issued_mask = issued_mask | oldest_oh[f];
        end
    end

    // Lowest-index free entry, from pre-edge busy state.
    always_comb begin
        alloc_idx = '0;
        for (int unsigned i = RS_DEPTH; i > 0; i--) begin
            if (!ent[i-1].busy) alloc_idx = IDX_W'(i - 1);
        end
    end

    always_comb begin
        dispatch_ready = (free_count != '0);
        do_dispatch    = dispatch_en & dispatch_ready;
        do_release     = release_en & ent[release_idx].busy;
        cap_pkt          = dispatch_packet;
        cap_pkt.t1.ready = dispatch_packet.t1.ready
                         | cdb_match(dispatch_packet.t1, cdb_en, cdb_tag);
        cap_pkt.t2.ready = dispatch_packet.t2.ready
                         | cdb_match(dispatch_packet.t2, cdb_en, cdb_tag);
    end

    // Release clears its row/column first; a dispatched entry then becomes
    // younger than every entry that stays busy across this edge.
    always_comb begin
        older_n = older;
        if (do_release) begin
            older_n[release_idx] = '0;
            for (int unsigned j = 0; j < RS_DEPTH; j++) older_n[j][release_idx] = 1'b0;
        end
        if (do_dispatch) begin
            older_n[alloc_idx] = '0;
            for (int unsigned j = 0; j < RS_DEPTH; j++) begin
                older_n[j][alloc_idx] = ent[j].busy
                                     && !(do_release && IDX_W'(j) == release_idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                ent[i].busy   <= 1'b0;
                ent[i].issued <= 1'b0;
            end
            older      <= '0;
            free_count <= (IDX_W+1)'(RS_DEPTH);
        end else begin
            for (int unsigned i = 0; i < RS_DEPTH; i++) begin
                if (ent[i].busy) begin
                    ent[i].pkt.t1.ready <= ent[i].pkt.t1.ready | wake1[i];
                    ent[i].pkt.t2.ready <= ent[i].pkt.t2.ready | wake2[i];
                end
                if (issued_mask[i]) ent[i].issued <= 1'b1;
                if (do_release && IDX_W'(i) == release_idx) begin
                    ent[i].busy   <= 1'b0;
                    ent[i].issued <= 1'b0;
                end
                if (do_dispatch && IDX_W'(i) == alloc_idx) begin
                    ent[i].busy   <= 1'b1;
                    ent[i].issued <= 1'b0;
                    ent[i].fu     <= FU_FIELD_W'(dispatch_fu);
                    ent[i].pkt    <= cap_pkt;
                end
            end
            older      <= older_n;
            free_count <= free_count + (IDX_W+1)'(do_release) - (IDX_W+1)'(do_dispatch);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush && release_en) begin
            assert (ent[release_idx].busy)
                else $error("rs_multi: release of idle entry %0d", release_idx);
        end
    end

endmodule

// File: tb/tb_rs_multi.sv
// tb_rs_multi: directed bench for rs_multi with a sequence-number based
// reference model compared against the DUT every cycle.
module tb_rs_multi;
    import rs_multi_pkg::*;

    localparam int D  = 8;
    localparam int NF = 3;
    localparam int CN = 2;
    localparam int IW = 3;
    localparam int FW = 2;
`ifdef RS_WAKEUP_ISSUE_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                        clock, reset, flush, dispatch_en, dispatch_ready;
    DECODER_PACKET               dispatch_packet;
    logic [FW-1:0]               dispatch_fu;
    logic [CN-1:0]               cdb_en;
    logic [CN-1:0][TAG_W-1:0]    cdb_tag;
    logic [NF-1:0]               fu_ready, issue_en;
    DECODER_PACKET [NF-1:0]      issue_packet;
    logic [NF-1:0][IW-1:0]       issue_idx;
    logic                        release_en;
    logic [IW-1:0]               release_idx;
    logic [IW:0]                 free_count;

    rs_multi #(.RS_DEPTH(D), .NUM_FU(NF), .CDB_N(CN)) dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .dispatch_en     (dispatch_en),
        .dispatch_packet (dispatch_packet),
        .dispatch_fu     (dispatch_fu),
        .dispatch_ready  (dispatch_ready),
        .cdb_en          (cdb_en),
        .cdb_tag         (cdb_tag),
        .fu_ready        (fu_ready),
        .issue_en        (issue_en),
        .issue_packet    (issue_packet),
        .issue_idx       (issue_idx),
        .release_en      (release_en),
        .release_idx     (release_idx),
        .free_count      (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference model: entry contents plus a dispatch sequence number for age.
    bit            m_valid = 1'b0;
    bit            m_busy   [D];
    bit            m_issued [D];
    int            m_fu     [D];
    int            m_seq    [D];
    DECODER_PACKET m_pkt    [D];
    int            seq_ctr = 0;
    int            m_free  = D;
    bit            e_found  [NF];
    int            e_idx    [NF];

    function automatic bit m_hit(SRC_TAG s);
        if (!s.valid) return 1'b0;
        for (int k = 0; k < CN; k++)
            if (cdb_en[k] && cdb_tag[k] == s.phys_reg) return 1'b1;
        return 1'b0;
    endfunction

    function automatic DECODER_PACKET m_view(int i);
        DECODER_PACKET p = m_pkt[i];
        if (BYP && m_hit(p.t1)) p.t1.ready = 1'b1;
        if (BYP && m_hit(p.t2)) p.t2.ready = 1'b1;
        return p;
    endfunction

    function automatic void m_select();
        for (int f = 0; f < NF; f++) begin
            e_found[f] = 1'b0;
            e_idx[f]   = 0;
            for (int i = 0; i < D; i++) begin
                DECODER_PACKET p = m_view(i);
                if (m_busy[i] && !m_issued[i] && m_fu[i] == f
                    && (!p.t1.valid || p.t1.ready) && (!p.t2.valid || p.t2.ready)
                    && (!e_found[f] || m_seq[i] < m_seq[e_idx[f]])) begin
                    e_found[f] = 1'b1;
                    e_idx[f]   = i;
                end
            end
        end
    endfunction

    always @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < D; i++) begin
                m_busy[i]   = 1'b0;
                m_issued[i] = 1'b0;
            end
            m_free  = D;
            m_valid = 1'b1;
        end else if (m_valid) begin
            int  alloc;
            bit  disp;
            alloc = -1;
            for (int i = D - 1; i >= 0; i--) if (!m_busy[i]) alloc = i;
            disp = dispatch_en && (m_free != 0);
            m_select();
            for (int f = 0; f < NF; f++)
                if (e_found[f] && fu_ready[f]) m_issued[e_idx[f]] = 1'b1;
            for (int i = 0; i < D; i++) begin
                if (m_busy[i] && m_hit(m_pkt[i].t1)) m_pkt[i].t1.ready = 1'b1;
                if (m_busy[i] && m_hit(m_pkt[i].t2)) m_pkt[i].t2.ready = 1'b1;
            end
            if (release_en && m_busy[release_idx]) begin
                m_busy[release_idx]   = 1'b0;
                m_issued[release_idx] = 1'b0;
                m_free++;
            end
            if (disp) begin
                m_busy[alloc]   = 1'b1;
                m_issued[alloc] = 1'b0;
                m_fu[alloc]     = int'(dispatch_fu);
                m_seq[alloc]    = seq_ctr++;
                m_pkt[alloc]    = dispatch_packet;
                if (m_hit(dispatch_packet.t1)) m_pkt[alloc].t1.ready = 1'b1;
                if (m_hit(dispatch_packet.t2)) m_pkt[alloc].t2.ready = 1'b1;
                m_free--;
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            m_select();
            for (int f = 0; f < NF; f++) begin
                bit exp_en;
                exp_en = e_found[f] && fu_ready[f];
                check($sformatf("issue_en[%0d]", f), issue_en[f], exp_en);
                if (exp_en) begin
                    check($sformatf("issue_idx[%0d]", f), issue_idx[f], e_idx[f]);
                    check($sformatf("issue_packet[%0d]", f), issue_packet[f], m_view(e_idx[f]));
                end
            end
            check("free_count", free_count, m_free);
            check("dispatch_ready", dispatch_ready, m_free != 0);
        end
    end

    function automatic DECODER_PACKET mk(int inst, int t1, bit v1, bit r1,
                                         int t2, bit v2, bit r2);
        DECODER_PACKET p;
        p.inst        = 32'(inst);
        p.dest        = TAG_W'(inst);
        p.t1.phys_reg = TAG_W'(t1);
        p.t1.valid    = v1;
        p.t1.ready    = r1;
        p.t2.phys_reg = TAG_W'(t2);
        p.t2.valid    = v2;
        p.t2.ready    = r2;
        return p;
    endfunction

    task automatic idle();
        flush = 0; dispatch_en = 0; dispatch_packet = '0; dispatch_fu = '0;
        cdb_en = '0; cdb_tag = '0; release_en = 0; release_idx = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic disp(DECODER_PACKET p, FU_CLASS fu);
        dispatch_en = 1; dispatch_packet = p; dispatch_fu = fu;
    endtask

    task automatic rel(int idx);
        release_en = 1; release_idx = IW'(idx);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1; fu_ready = '0; idle();
        tick(); tick();
        reset = 0;
        #1;
        check("reset free_count", free_count, 8);
        check("reset dispatch_ready", dispatch_ready, 1);
        check("reset issue_en", issue_en, 0);

        // Fill with ready ALU ops; each issues one cycle after dispatch.
        fu_ready = 3'b111;
        for (int k = 0; k < 8; k++) begin
            disp(mk(100 + k, k, 1, 1, 0, 0, 0), FU_ALU);
            #1;
            if (k > 0) begin
                check("fill issue_en", issue_en[0], 1);
                check("fill issue_idx", issue_idx[0], k - 1);
            end
            tick();
        end
        disp(mk(200, 1, 1, 1, 0, 0, 0), FU_ALU);   // full: must be ignored
        #1;
        check("full free_count", free_count, 0);
        check("full dispatch_ready", dispatch_ready, 0);
        check("full issue_idx", issue_idx[0], 7);
        tick();
        for (int k = 0; k < 8; k++) begin rel(k); tick(); end
        #1;
        check("drained free_count", free_count, 8);

        // CDB wakeup on port 1; invalid t2 with same tag must not matter.
        disp(mk(300, 5, 1, 0, 5, 0, 0), FU_ALU);
        tick(); #1;
        check("wait issue_en", issue_en, 0);
        cdb_en = 2'b10; cdb_tag[0] = 6'd7; cdb_tag[1] = 6'd5;
        #1;
        check("wake cycle issue_en", issue_en[0], BYP);
        tick(); #1;
        check("after wake issue_en", issue_en[0], !BYP);
        tick(); rel(0); tick();

        // Dispatch-cycle capture of a broadcast tag.
        disp(mk(400, 0, 0, 0, 9, 1, 0), FU_ALU);
        cdb_en = 2'b01; cdb_tag[0] = 6'd9;
        tick(); #1;
        check("capture issue_en", issue_en[0], 1);
        check("capture t2.ready", issue_packet[0].t2.ready, 1);
        check("capture issue_idx", issue_idx[0], 0);
        tick(); rel(0); tick();

        // Age order beats index order.
        fu_ready = 3'b000;
        for (int k = 0; k < 3; k++) begin disp(mk(500 + k, 1, 1, 1, 2, 1, 1), FU_MULT); tick(); end
        rel(1); tick();
        disp(mk(510, 1, 1, 1, 0, 0, 0), FU_MULT); tick();
        fu_ready = 3'b010; #1;
        check("age 1st idx", issue_idx[1], 0);
        tick(); #1;
        check("age 2nd idx", issue_idx[1], 2);
        tick(); #1;
        check("age 3rd idx", issue_idx[1], 1);
        check("age 3rd inst", issue_packet[1].inst, 510);
        tick();
        fu_ready = 3'b000;
        rel(0); tick(); rel(2); tick(); rel(1); tick();

        // Independent classes; MEM held while its port is busy.
        disp(mk(600, 0, 0, 0, 0, 0, 0), FU_ALU); tick();
        disp(mk(601, 0, 0, 0, 0, 0, 0), FU_MEM); tick();
        fu_ready = 3'b101; #1;
        check("dual issue_en", issue_en, 3'b101);
        check("dual mem idx", issue_idx[2], 1);
        tick();
        fu_ready = 3'b000;
        rel(0); tick(); rel(1); tick();
        fu_ready = 3'b001;
        disp(mk(700, 3, 1, 1, 0, 0, 0), FU_MEM); tick(); #1;
        check("mem held 1", issue_en, 0);
        tick(); #1;
        check("mem held 2", issue_en, 0);
        fu_ready = 3'b100; #1;
        check("mem released", issue_en, 3'b100);
        tick();
        fu_ready = 3'b000;
        rel(0); tick();

        // Flush beats dispatch and release in the same cycle.
        disp(mk(800, 0, 0, 0, 0, 0, 0), FU_ALU); tick();
        disp(mk(801, 0, 0, 0, 0, 0, 0), FU_ALU); tick();
        flush = 1; fu_ready = 3'b111;
        disp(mk(802, 0, 0, 0, 0, 0, 0), FU_ALU); rel(0);
        tick(); #1;
        check("flush free_count", free_count, 8);
        check("flush issue_en", issue_en, 0);
        check("flush dispatch_ready", dispatch_ready, 1);
        disp(mk(803, 0, 0, 0, 0, 0, 0), FU_ALU); tick(); #1;
        check("post-flush idx", issue_idx[0], 0);
        check("post-flush inst", issue_packet[0].inst, 803);
        tick(); rel(0); tick();

        // Two ports carrying the same tag, second source woken later.
        fu_ready = 3'b001;
        disp(mk(900, 12, 1, 0, 13, 1, 0), FU_ALU); tick();
        cdb_en = 2'b11; cdb_tag[0] = 6'd12; cdb_tag[1] = 6'd12; #1;
        check("dup tag issue_en", issue_en, 0);
        tick();
        cdb_en = 2'b01; cdb_tag[0] = 6'd13; #1;
        check("t2 wake issue_en", issue_en[0], BYP);
        tick(); #1;
        check("t2 after issue_en", issue_en[0], !BYP);
        tick(); rel(0); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
